// File: rtl/sm_pkg.sv
// Shared definitions for the feeder -> scoring module -> results path.
// Holds the default score/ID widths, the score bias and the result record type.
package sm_pkg;

   localparam int SCORE_WIDTH = 12;
   localparam int ID_WIDTH    = 48;
   localparam int ZERO        = 2 ** (SCORE_WIDTH - 1);

   typedef struct packed {
      logic [ID_WIDTH-1:0]    id;
      logic [SCORE_WIDTH-1:0] score;
      logic                   toggle;
   } sm_result_t;

endpackage

// File: rtl/sm_result_fifo.sv
// Dual-write, single-read first-word-fall-through FIFO for result records.
// Callers only assert wr0/wr1 when room exists; wr0 lands ahead of wr1.
module sm_result_fifo #(
   parameter int WIDTH = 61,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr0,
   input  logic [WIDTH-1:0] data0,
   input  logic             wr1,
   input  logic [WIDTH-1:0] data1,
   input  logic             pop,
   output logic [LW-1:0]    level,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [LW-1:0]    level_q, level_d;

   always_comb begin
      wrPtr_d = wrPtr_q + AW'(wr0) + AW'(wr1);
      rdPtr_d = rdPtr_q + AW'(pop);
      level_d = level_q + LW'(wr0) + LW'(wr1) - LW'(pop);
   end

   // Storage needs no reset: entries are only visible through level.
   always_ff @(posedge clk) begin
      if (wr0) mem_q[wrPtr_q] <= data0;
      if (wr1) mem_q[wr0 ? wrPtr_q + AW'(1) : wrPtr_q] <= data1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;
   assign head  = mem_q[rdPtr_q];

endmodule

// File: rtl/sm_result_collector.sv
// Captures toggle-0/1 result edges, removes the score bias and queues records
// for a valid/ready consumer. Define SMRC_BEST_TRACK_EN to add best-score tracking.
module sm_result_collector #(
   parameter int SCORE_WIDTH = sm_pkg::SCORE_WIDTH,
   parameter int ID_WIDTH    = sm_pkg::ID_WIDTH,
   parameter int ZERO        = 2 ** (SCORE_WIDTH - 1),
   parameter int DEPTH       = 16,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vld0,
   input  logic [SCORE_WIDTH-1:0] result0,
   input  logic [ID_WIDTH-1:0]    id0,
   input  logic                   vld1,
   input  logic [SCORE_WIDTH-1:0] result1,
   input  logic [ID_WIDTH-1:0]    id1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ID_WIDTH-1:0]    out_id,
   output logic [SCORE_WIDTH-1:0] out_score,
   output logic                   out_toggle,
   output logic [LW-1:0]          level,
   output logic                   overflow,
   output logic [15:0]            drop_cnt
`ifdef SMRC_BEST_TRACK_EN
   ,
   output logic                   best_valid,
   output logic [SCORE_WIDTH-1:0] best_score,
   output logic [ID_WIDTH-1:0]    best_id
`endif
);

   import sm_pkg::*;

   localparam int RW = ID_WIDTH + SCORE_WIDTH + 1;
   localparam logic [SCORE_WIDTH-1:0] ZERO_V = SCORE_WIDTH'(ZERO);

   logic                   vld0_q, vld1_q;
   logic                   ev0, ev1;
   logic [SCORE_WIDTH-1:0] score0, score1;
   logic                   pop;
   logic [LW:0]            freeSlots;
   logic                   wr0, wr1;
   logic [1:0]             dropNum;
   logic [16:0]            dropSum;
   logic                   overflow_q, overflow_d;
   logic [15:0]            dropCnt_q, dropCnt_d;
   logic [RW-1:0]          head;

   assign ev0    = vld0 & ~vld0_q;
   assign ev1    = vld1 & ~vld1_q;
   assign score0 = result0 + ZERO_V;
   assign score1 = result1 + ZERO_V;
   assign pop    = out_valid & out_ready;

   // A slot freed by this cycle's pop is usable by this cycle's writes.
   always_comb begin
      freeSlots = (LW+1)'(DEPTH) - {1'b0, level} + (LW+1)'(pop);
      wr0       = ev0 & (freeSlots != '0);
      wr1       = ev1 & (freeSlots >= (ev0 ? (LW+1)'(2) : (LW+1)'(1)));
      dropNum   = {1'b0, ev0 & ~wr0} + {1'b0, ev1 & ~wr1};
      dropSum   = {1'b0, dropCnt_q} + 17'(dropNum);
      dropCnt_d = dropSum[16] ? 16'hFFFF : dropSum[15:0];
      overflow_d = overflow_q | (dropNum != 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld0_q     <= 1'b0;
         vld1_q     <= 1'b0;
         overflow_q <= 1'b0;
         dropCnt_q  <= '0;
      end else begin
         vld0_q     <= vld0;
         vld1_q     <= vld1;
         overflow_q <= overflow_d;
         dropCnt_q  <= dropCnt_d;
      end
   end

   sm_result_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) uFifo (
      .clk   (clk),
      .rst   (rst),
      .wr0   (wr0),
      .data0 ({id0, score0, 1'b0}),
      .wr1   (wr1),
      .data1 ({id1, score1, 1'b1}),
      .pop   (pop),
      .level (level),
      .head  (head)
   );

   // Head fields are forced to zero while empty so idle outputs are clean.
   assign out_valid  = (level != '0);
   assign out_id     = out_valid ? head[RW-1 -: ID_WIDTH] : '0;
   assign out_score  = out_valid ? head[SCORE_WIDTH:1] : '0;
   assign out_toggle = out_valid ? head[0] : 1'b0;
   assign overflow   = overflow_q;
   assign drop_cnt   = dropCnt_q;

`ifdef SMRC_BEST_TRACK_EN
   logic                   bestValid_q, bestValid_d;
   logic [SCORE_WIDTH-1:0] bestScore_q, bestScore_d;
   logic [ID_WIDTH-1:0]    bestId_q, bestId_d;

   // Strict greater-than keeps the earlier record on ties; toggle-0 is tried first.
   always_comb begin
      bestValid_d = bestValid_q;
      bestScore_d = bestScore_q;
      bestId_d    = bestId_q;
      if (ev0 && (!bestValid_d || score0 > bestScore_d)) begin
         bestValid_d = 1'b1;
         bestScore_d = score0;
         bestId_d    = id0;
      end
      if (ev1 && (!bestValid_d || score1 > bestScore_d)) begin
         bestValid_d = 1'b1;
         bestScore_d = score1;
         bestId_d    = id1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bestValid_q <= 1'b0;
         bestScore_q <= '0;
         bestId_q    <= '0;
      end else begin
         bestValid_q <= bestValid_d;
         bestScore_q <= bestScore_d;
         bestId_q    <= bestId_d;
      end
   end

   assign best_valid = bestValid_q;
   assign best_score = bestScore_q;
   assign best_id    = bestId_q;
`endif

endmodule
